fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register. Holds the program counter, drives the instruction-memory address, and latches the fetched instruction and its PC for the decode stage that feeds `id_ex`. Applies stall, branch/jump redirect with flush, and halt detection, so decode always sees either a valid instruction or an explicit NOP bubble.

## Interface
- `PC_WIDTH`, 11: word-address width of PC and instruction memory (2048 words).
- `INSTR_WIDTH`, 32: instruction width.
- `RESET_PC`, 0: PC value after reset.
- `HALT_OPCODE`, 6'b111111: opcode (instr[31:26]) that halts fetch.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `stall_in` input 1: load-use stall from hazard unit; hold PC and IF/ID.
- `branch_taken_in` input 1: resolved taken branch; redirect and flush.
- `branch_dest_in` input PC_WIDTH: branch target.
- `jump_in` input 1: jump decoded in ID; redirect and flush.
- `jump_dest_in` input PC_WIDTH: jump target.
- `imem_addr_out` output PC_WIDTH: equals PC (combinational from PC register).
- `imem_data_in` input INSTR_WIDTH: combinational-read instruction at `imem_addr_out`.
- `instruction_out` output INSTR_WIDTH: IF/ID instruction.
- `current_pc_out` output PC_WIDTH: PC of `instruction_out`.
- `pc_plus_one_out` output PC_WIDTH: `current_pc_out + 1`, registered.
- `valid_out` output 1: IF/ID holds a real instruction (0 = bubble).
- `halted_out` output 1: fetch FSM in HALTED.
- `fetch_count_out` output 32: count of valid instructions latched into IF/ID.

## Operation
- FSM states: RUN, HALTED. Reset → RUN.
- Per-edge priority: reset > branch > jump > stall > HALTED > normal fetch.
- Reset: PC=RESET_PC; instruction_out=0, current_pc_out=0, pc_plus_one_out=0, valid_out=0, halted_out=0, fetch_count_out=0.
- Branch (`branch_taken_in`=1): PC←branch_dest_in; IF/ID←bubble (instruction 0, valid 0, pc fields 0); state←RUN. Wins over simultaneous jump (branch is older).
- Jump (no branch): PC←jump_dest_in; IF/ID←bubble; state←RUN.
- Redirect overrides stall; the stalled instruction is flushed.
- Stall (no redirect): PC, IF/ID, state, fetch_count all hold.
- RUN, normal: IF/ID←{imem_data_in, PC, PC+1, valid=1}; PC←PC+1; fetch_count+1.
- If fetched instr[31:26]==HALT_OPCODE in RUN normal: instruction latched as above (valid=1, counted), PC holds (not incremented), state←HALTED.
- HALTED, no redirect: PC holds; IF/ID←bubble each edge; fetch_count holds.
- Redirect in HALTED exits to RUN (halt was speculative behind a taken branch/jump).
- PC arithmetic modulo 2^PC_WIDTH: 2047+1 → 0, `pc_plus_one_out` likewise wraps. fetch_count wraps at 2^32.
- Bubble encoding: instruction_out=0 (sll $0,$0,0), valid_out=0.

## Timing
- Fetch latency: instruction at PC in cycle N appears on IF/ID outputs after edge N.
- Redirect asserted in cycle N: edge N loads target and bubble; target instruction in IF/ID after edge N+1 (one-bubble penalty from this stage).
- Stall: each stalled cycle adds one held cycle; release resumes with the same instruction next edge.
- Outputs change only after rising edge; downstream `id_ex` samples on falling edge, so IF/ID values are stable half a cycle before capture.
- Reset mid-operation (any state, any stall/redirect) takes effect at that edge with the values above.

## Test plan
- Reset then free-run, imem[i]=i+0x100: after 3 edges instruction_out=0x102, current_pc_out=2, pc_plus_one_out=3, fetch_count_out=3.
- Stall held 2 cycles while IF/ID holds PC 5: outputs and imem_addr_out frozen (imem_addr=6); release → PC 6 latched next edge, count +1 only once.
- branch_taken_in and jump_in together with dest 0x040 / 0x080, also stall_in=1: next edge valid_out=0, instruction_out=0, imem_addr_out=0x040; following edge current_pc_out=0x040.
- HALT opcode at PC 10: halt latched valid, halted_out=1, imem_addr_out stays 10, subsequent edges valid_out=0, count frozen; branch to 0x020 → halted_out=0, fetch resumes at 0x020.
- PC at 2047 free-run: current_pc_out=2047 with pc_plus_one_out=0, next fetch at 0.
- Assert reset while HALTED and stalled: after edge all outputs at reset values, imem_addr_out=RESET_PC, state RUN.

Source files
------------

// File: rtl/fetch_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_if : control, instruction-memory and IF/ID bundle        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 32
);
  logic                   stall_in;
  logic                   branch_taken_in;
  logic [PC_WIDTH-1:0]    branch_dest_in;
  logic                   jump_in;
  logic [PC_WIDTH-1:0]    jump_dest_in;
  logic [PC_WIDTH-1:0]    imem_addr_out;
  logic [INSTR_WIDTH-1:0] imem_data_in;
  logic [INSTR_WIDTH-1:0] instruction_out;
  logic [PC_WIDTH-1:0]    current_pc_out;
  logic [PC_WIDTH-1:0]    pc_plus_one_out;
  logic                   valid_out;
  logic                   halted_out;
  logic [31:0]            fetch_count_out;

  modport master (
    input  stall_in, branch_taken_in, branch_dest_in, jump_in, jump_dest_in,
    input  imem_data_in,
    output imem_addr_out, instruction_out, current_pc_out, pc_plus_one_out,
    output valid_out, halted_out, fetch_count_out
  );

  modport slave (
    output stall_in, branch_taken_in, branch_dest_in, jump_in, jump_dest_in,
    output imem_data_in,
    input  imem_addr_out, instruction_out, current_pc_out, pc_plus_one_out,
    input  valid_out, halted_out, fetch_count_out
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage : PC, instruction fetch and IF/ID register with halt FSM |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_stage #(
  parameter int             PC_WIDTH    = 11,
  parameter int             INSTR_WIDTH = 32,
  parameter logic [10:0]    RESET_PC    = 11'd0,
  parameter logic [5:0]     HALT_OPCODE = 6'b111111
) (
  input  wire                clock,
  input  wire                reset,
  fetch_stage_if.master      bus
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    cur_pc_q, cur_pc_d;
  logic [PC_WIDTH-1:0]    pc_p1_q, pc_p1_d;
  logic                   valid_q, valid_d;
  logic [31:0]            count_q, count_d;

  logic [PC_WIDTH-1:0]    pc_inc;
  logic                   is_halt;

  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign is_halt = (bus.imem_data_in[INSTR_WIDTH-1 -: 6] == HALT_OPCODE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cur_pc_d = cur_pc_q;
    pc_p1_d  = pc_p1_q;
    valid_d  = valid_q;
    count_d  = count_q;

    if (bus.branch_taken_in || bus.jump_in) begin
      // Branch is older than the jump in ID, so it wins; redirect also flushes a stalled slot.
      pc_d     = bus.branch_taken_in ? bus.branch_dest_in : bus.jump_dest_in;
      instr_d  = '0;
      cur_pc_d = '0;
      pc_p1_d  = '0;
      valid_d  = 1'b0;
      state_d  = RUN;
    end else if (bus.stall_in) begin
      state_d = state_q;
    end else if (state_q == HALTED) begin
      instr_d  = '0;
      cur_pc_d = '0;
      pc_p1_d  = '0;
      valid_d  = 1'b0;
    end else begin
      instr_d  = bus.imem_data_in;
      cur_pc_d = pc_q;
      pc_p1_d  = pc_inc;
      valid_d  = 1'b1;
      count_d  = count_q + 32'd1;
      if (is_halt) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= PC_WIDTH'(RESET_PC);
      instr_q  <= '0;
      cur_pc_q <= '0;
      pc_p1_q  <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cur_pc_q <= cur_pc_d;
      pc_p1_q  <= pc_p1_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign bus.imem_addr_out   = pc_q;
  assign bus.instruction_out = instr_q;
  assign bus.current_pc_out  = cur_pc_q;
  assign bus.pc_plus_one_out = pc_p1_q;
  assign bus.valid_out       = valid_q;
  assign bus.halted_out      = (state_q == HALTED);
  assign bus.fetch_count_out = count_q;

endmodule
`default_nettype wire
